// File: rtl/seq_ser_pkg.sv
// Shared types and helpers for the sequence-detector serializer.
// Holds the FSM state enum, the default word width and the length clamp.
package seq_ser_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } seq_ser_state_e;

    localparam int SEQ_SER_DEFAULT_WIDTH = 64;

    // A requested length of 0, or one longer than the word, means "send the whole word".
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned width);
        return ((len == 0) || (len > width)) ? width : len;
    endfunction

endpackage

// File: rtl/seq_ser_cnt.sv
// Loadable down-counter used to track how many serial bits remain in a pass.
// Load has priority over enable; the count saturates at zero.
module seq_ser_cnt #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero,
    output logic         is_one
);

    logic [W-1:0] count_d;
    logic [W-1:0] count_q;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero   = (count_q == '0);
    assign is_one = (count_q == W'(1));

endmodule

// File: rtl/seq_serializer.sv
// Parallel-to-serial feeder for the 001/110 detector: sends a loaded word MSB-first on x.
// Define SEQ_SER_LOOP_EN to build the copy register that lets a word repeat without a gap.
module seq_serializer
    import seq_ser_pkg::*;
#(
    parameter int WIDTH = SEQ_SER_DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic [CNT_W-1:0] load_len,
    input  logic             hold,
    input  logic             loop,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done
);

    seq_ser_state_e   state_d, state_q;
    logic [WIDTH-1:0] sreg_d, sreg_q;
    logic             x_d, x_q;
    logic             x_valid_d, x_valid_q;
    logic             done_d, done_q;

    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_en;
    logic             cnt_is_one;
    logic             cnt_zero_unused;
    logic [CNT_W-1:0] len_clamped;

`ifdef SEQ_SER_LOOP_EN
    logic [WIDTH-1:0] saved_word_d, saved_word_q;
    logic [CNT_W-1:0] saved_len_d, saved_len_q;
`else
    logic unused_loop;
    assign unused_loop = loop;
`endif

    assign len_clamped = CNT_W'(clamp_len(32'(load_len), 32'(WIDTH)));

    // The counter holds the bits of the pass not yet retired, including the one on x.
    seq_ser_cnt #(
        .W(CNT_W)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (cnt_en),
        .zero     (cnt_zero_unused),
        .is_one   (cnt_is_one)
    );

    // x/x_valid are registered, so each edge prepares the bit shown in the following cycle.
    always_comb begin
        state_d      = state_q;
        sreg_d       = sreg_q;
        x_d          = x_q;
        x_valid_d    = 1'b0;
        done_d       = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = len_clamped;
        cnt_en       = 1'b0;
`ifdef SEQ_SER_LOOP_EN
        saved_word_d = saved_word_q;
        saved_len_d  = saved_len_q;
`endif
        case (state_q)
            IDLE: begin
                x_d = 1'b0;
                if (load_valid) begin
                    state_d   = SHIFT;
                    x_d       = load_data[WIDTH-1];
                    x_valid_d = 1'b1;
                    sreg_d    = load_data << 1;
                    cnt_load  = 1'b1;
`ifdef SEQ_SER_LOOP_EN
                    saved_word_d = load_data;
                    saved_len_d  = len_clamped;
`endif
                end
            end
            SHIFT: begin
                if (!hold) begin
                    cnt_en = 1'b1;
                    if (cnt_is_one) begin
                        done_d = 1'b1;
`ifdef SEQ_SER_LOOP_EN
                        if (loop) begin
                            x_d          = saved_word_q[WIDTH-1];
                            x_valid_d    = 1'b1;
                            sreg_d       = saved_word_q << 1;
                            cnt_load     = 1'b1;
                            cnt_load_val = saved_len_q;
                        end else begin
                            state_d = IDLE;
                            x_d     = 1'b0;
                            sreg_d  = '0;
                        end
`else
                        state_d = IDLE;
                        x_d     = 1'b0;
                        sreg_d  = '0;
`endif
                    end else begin
                        x_d       = sreg_q[WIDTH-1];
                        x_valid_d = 1'b1;
                        sreg_d    = sreg_q << 1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            sreg_q    <= '0;
            x_q       <= 1'b0;
            x_valid_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            x_q       <= x_d;
            x_valid_q <= x_valid_d;
            done_q    <= done_d;
        end
    end

`ifdef SEQ_SER_LOOP_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            saved_word_q <= '0;
            saved_len_q  <= '0;
        end else begin
            saved_word_q <= saved_word_d;
            saved_len_q  <= saved_len_d;
        end
    end
`endif

    assign x          = x_q;
    assign x_valid    = x_valid_q;
    assign done       = done_q;
    assign busy       = (state_q == SHIFT);
    assign load_ready = (state_q == IDLE);

endmodule

// File: doc/seq_serializer.md
# seq_serializer

Parallel-to-serial feeder for the sequence-detector stage. Accepts a stimulus word of up to WIDTH bits over a valid/ready load handshake and drives it MSB-first, one bit per clock, onto the detector's serial input `x`. The block sits directly upstream of the 001/110 Moore detector, so an entire test sequence such as 00110011 can be applied from a single parallel load. It supports stalling and reports when a pass has completed.

## Interface
- WIDTH, 64: maximum sequence length in bits.
- CNT_W, $clog2(WIDTH+1): width of the length field and bit counter (derived).

- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- load_valid  input  1  load request.
- load_ready  output  1  block can accept a load.
- load_data  input  WIDTH  sequence; bit [WIDTH-1] is sent first.
- load_len  input  CNT_W  number of bits to send. 0 or >WIDTH means WIDTH.
- hold  input  1  stall shifting while 1.
- loop  input  1  repeat the current word (used only with SEQ_SER_LOOP_EN).
- x  output  1  serial bit to the detector.
- x_valid  output  1  `x` carries a new bit this cycle.
- busy  output  1  a sequence is in progress.
- done  output  1  one-cycle pulse when a pass completes.

## Operation
- States:
  - IDLE: load_ready=1, busy=0.
  - SHIFT: load_ready=0, busy=1.
- Load:
  - Accepted on the edge where load_valid & load_ready.
  - Latches load_data into the shift register and the clamped length into the bit counter.
  - Moves IDLE→SHIFT.
- SHIFT with hold=0:
  - x = shift register MSB, x_valid=1.
  - At each edge the register shifts left (zero fill) and the counter decrements.
- SHIFT with hold=1:
  - Register and counter freeze.
  - x keeps its value; x_valid=0.
- Last bit (counter==1, hold=0): at that edge go SHIFT→IDLE and set done=1 for the following cycle.
- In IDLE: x=0, x_valid=0.
- load_valid while busy: ignored. No queuing, no error.
- Reset, asserted at any time including mid-sequence:
  - State=IDLE, shift register=0, counter=0.
  - x=0, x_valid=0, busy=0, done=0, load_ready=1.
  - The partial sequence is discarded and no done pulse is produced.

## Timing
- Load accepted at edge E0. Bit k (k=0..len-1) is on x during cycle k+1 after E0, with no holds.
- done is high during cycle len+1. In that same cycle load_ready=1, so the next load can be accepted at the end of that cycle.
- Back-to-back sequences therefore leave a one-cycle gap with x_valid=0.
- Each hold cycle adds exactly one cycle of latency.
- hold in IDLE has no effect.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs except load_ready, which is state-only.

## Configuration
- SEQ_SER_LOOP_EN defined:
  - The saved word and length are kept in a copy register.
  - If loop=1 when the last bit shifts, both are reloaded and SHIFT continues with no gap. Bit 0 of the next pass follows the last bit on the next cycle.
  - done pulses once per completed pass, coincident with bit 0 of the next pass.
  - loop=0 exits to IDLE as normal.
- SEQ_SER_LOOP_EN undefined: the loop input is ignored and no copy register is built.

## Structure
- Package seq_ser_pkg holds:
  - State enum (IDLE, SHIFT).
  - Default WIDTH.
  - Length-clamp function that maps 0 or >WIDTH to WIDTH.
- Sub-module seq_ser_cnt: loadable down-counter with enable, zero, and is-one flags.

## Test plan
- Basic sequence:
  - Stimulus: load 8'b00110011 (placed in the top 8 bits), len=8.
  - Required response: x=0,0,1,1,0,0,1,1 on cycles 1–8 with x_valid=1; done on cycle 9. The downstream detector then outputs y=00010101.
- Zero length:
  - Stimulus: len=0 with WIDTH=64, data=all-ones.
  - Required response: exactly 64 ones, then done.
- Hold:
  - Stimulus: len=4, data=1010, hold asserted for 2 cycles after bit 1.
  - Required response: x stays 0 with x_valid=0 for 2 cycles; done arrives 2 cycles late; bit order is preserved.
- Reset mid-sequence:
  - Stimulus: assert rst low during bit 3 of an 8-bit load.
  - Required response: outputs immediately go to reset values with no done; the next load is accepted normally.
- Load while busy:
  - Stimulus: assert load_valid with different data while in SHIFT.
  - Required response: load_ready=0, the original sequence completes unchanged, and the second load is accepted in the done cycle.
- Loop (SEQ_SER_LOOP_EN):
  - Stimulus: len=3, data=110, loop=1.
  - Required response: a continuous 110110110 stream with no gap and a done pulse every 3 cycles; clearing loop ends the stream after the current pass.
